// File: rtl/scm_pkg.sv
// Shared helpers for the latch-based register file: geometry derivation and
// wrapping lane-address arithmetic.
package scm_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    function automatic int unsigned scm_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned scm_nbytes(input int unsigned data_width);
        return data_width / BYTE_WIDTH;
    endfunction

    // Lane j of a wide read sits at (base + j) modulo the memory depth.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned addr_width);
        return (base + offset) & (scm_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// Glitch-free clock gate: enable is captured while the clock is low.
module cluster_clock_gating (
    input  logic clk,
    input  logic en,
    input  logic test_en,
    output logic clk_gated
);

    logic en_latched;

    always_latch begin
        if (!clk) en_latched <= en | test_en;
    end

    assign clk_gated = clk & en_latched;

endmodule

// File: rtl/scm_write_arbiter.sv
// Fixed-priority write resolution: lowest requesting port wins each address;
// emits per-port grants and per-word byte/port one-hots.
module scm_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned N_WRITE    = 1,
    parameter int unsigned NBYTES     = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic [N_WRITE-1:0]                 write_enable,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] write_addr,
    input  logic [N_WRITE-1:0][NBYTES-1:0]     write_be,
    output logic [N_WRITE-1:0]                 grant,
    output logic [DEPTH-1:0][NBYTES-1:0]       word_be,
    output logic [DEPTH-1:0][N_WRITE-1:0]      word_port
);

    logic [N_WRITE-1:0] req;

    always_comb begin
        req       = '0;
        grant     = '0;
        word_be   = '0;
        word_port = '0;
        // A port with no byte enabled does not request and cannot block others.
        for (int p = 0; p < N_WRITE; p++) req[p] = write_enable[p] & (|write_be[p]);
        for (int p = 0; p < N_WRITE; p++) begin
            grant[p] = req[p];
            for (int q = 0; q < N_WRITE; q++) begin
                if (q < p && req[q] && write_addr[q] == write_addr[p]) grant[p] = 1'b0;
            end
        end
        for (int p = 0; p < N_WRITE; p++) begin
            if (grant[p]) begin
                word_be[write_addr[p]]      = write_be[p];
                word_port[write_addr[p]][p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_file_nw_mr_wide_read.sv
// Latch-based register file: N_WRITE narrow byte-enabled write ports,
// N_READ wide read ports returning RATIO consecutive words with wrap-around.
module register_file_nw_mr_wide_read
    import scm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned WDATA_WIDTH = 64,
    parameter int unsigned RATIO       = 2,
    parameter int unsigned N_READ      = 1,
    parameter int unsigned N_WRITE     = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_READ-1:0]                        ReadEnable,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]        ReadAddr,
    output logic [N_READ-1:0][RATIO-1:0][WDATA_WIDTH-1:0] ReadData,
    output logic [N_READ-1:0]                        ReadValid,
    input  logic [N_WRITE-1:0]                       WriteEnable,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]       WriteAddr,
    input  logic [N_WRITE-1:0][WDATA_WIDTH-1:0]      WriteData,
    input  logic [N_WRITE-1:0][WDATA_WIDTH/8-1:0]    WriteBE,
    output logic [N_WRITE-1:0]                       WriteGrant
);

    localparam int unsigned DEPTH  = scm_depth(ADDR_WIDTH);
    localparam int unsigned NBYTES = scm_nbytes(WDATA_WIDTH);

    logic [N_WRITE-1:0]                  grant;
    logic [DEPTH-1:0][NBYTES-1:0]        word_be, word_be_q;
    logic [DEPTH-1:0][N_WRITE-1:0]       word_port, word_port_q;
    logic [N_WRITE-1:0][WDATA_WIDTH-1:0] wdata_q;
    logic [DEPTH-1:0][WDATA_WIDTH-1:0]   word_wdata;
    logic [DEPTH-1:0][WDATA_WIDTH-1:0]   mem;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]   raddr_q;
    logic [N_READ-1:0]                   rvalid_q;
    logic                                clk_global;

    scm_write_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .N_WRITE   (N_WRITE),
        .NBYTES    (NBYTES),
        .DEPTH     (DEPTH)
    ) u_arbiter (
        .write_enable(WriteEnable),
        .write_addr  (WriteAddr),
        .write_be    (WriteBE),
        .grant       (grant),
        .word_be     (word_be),
        .word_port   (word_port)
    );

    assign WriteGrant = grant;

    // Staging registers feed the latches during the high phase after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_be_q   <= '0;
            word_port_q <= '0;
            wdata_q     <= '0;
        end else begin
            word_be_q   <= word_be;
            word_port_q <= word_port;
            for (int p = 0; p < N_WRITE; p++) begin
                if (grant[p]) wdata_q[p] <= WriteData[p];
            end
        end
    end

    always_comb begin
        word_wdata = '0;
        for (int w = 0; w < DEPTH; w++) begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (word_port_q[w][p]) word_wdata[w] = wdata_q[p];
            end
        end
    end

    cluster_clock_gating u_cg_global (
        .clk      (clk),
        .en       (|grant),
        .test_en  (1'b0),
        .clk_gated(clk_global)
    );

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        for (genvar b = 0; b < NBYTES; b++) begin : g_byte
            logic                  clk_byte;
            logic [BYTE_WIDTH-1:0] q;

            cluster_clock_gating u_cg (
                .clk      (clk_global),
                .en       (word_be[w][b]),
                .test_en  (1'b0),
                .clk_gated(clk_byte)
            );

            // Staged one-hot qualifies the gate so an async reset aborts the write.
            always_latch begin
                if (clk_byte && word_be_q[w][b]) q <= word_wdata[w][b*BYTE_WIDTH +: BYTE_WIDTH];
            end

            assign mem[w][b*BYTE_WIDTH +: BYTE_WIDTH] = q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q  <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= ReadEnable;
            for (int p = 0; p < N_READ; p++) begin
                if (ReadEnable[p]) raddr_q[p] <= ReadAddr[p];
            end
        end
    end

    assign ReadValid = rvalid_q;

    always_comb begin
        ReadData = '0;
        for (int p = 0; p < N_READ; p++) begin
            for (int j = 0; j < RATIO; j++) begin
                ReadData[p][j] = mem[ADDR_WIDTH'(wrap_add(32'(raddr_q[p]), j, ADDR_WIDTH))];
            end
        end
    end

endmodule

// File: doc/register_file_nw_mr_wide_read.md
Name: register_file_nw_mr_wide_read

Overview:
- Latch-based standard-cell memory with N_WRITE narrow write ports and N_READ wide read ports.
- Each read returns RATIO consecutive narrow words starting at any narrow-word address, wrapping modulo depth.
- Generalises the single-write, fixed 2:1 wide-read SCM with per-byte write enables, fixed-priority write-port arbitration, read-valid tracking and wrap-around.
- Used as a shared operand/instruction buffer in the cluster.

Parameters:
- ADDR_WIDTH, 5, narrow-word address width; DEPTH = 2**ADDR_WIDTH words.
- WDATA_WIDTH, 64, narrow word width; multiple of 8.
- RATIO, 2, narrow words per read beat; power of 2, 1..DEPTH.
- N_READ, 1, read port count.
- N_WRITE, 1, write port count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ReadEnable  in  N_READ  per-port read request.
- ReadAddr  in  N_READ x ADDR_WIDTH  narrow-word start address.
- ReadData  out  N_READ x RATIO x WDATA_WIDTH  lane j = word (ReadAddr+j) mod DEPTH.
- ReadValid  out  N_READ  ReadData holds the result of an accepted read.
- WriteEnable  in  N_WRITE  per-port write request.
- WriteAddr  in  N_WRITE x ADDR_WIDTH  target word.
- WriteData  in  N_WRITE x WDATA_WIDTH  write data.
- WriteBE  in  N_WRITE x WDATA_WIDTH/8  byte enables.
- WriteGrant  out  N_WRITE  combinational; write accepted this cycle.

Behaviour:
- Reset: read address registers, ReadValid, write staging registers (data, BE, one-hot) cleared to 0. Storage latches are not reset and their content is undefined until written.
- ReadData after reset is the content of words 0..RATIO-1.
- Read: on a posedge with ReadEnable[p]=1, ReadAddr[p] is registered and ReadValid[p] is set to 1 for that cycle.
  - With ReadEnable[p]=0, both the address and ReadData hold, and ReadValid[p] clears to 0.
  - Latency is 1 cycle; data is valid for the whole following cycle.
  - Lane index arithmetic is ADDR_WIDTH bits and wraps. Example: DEPTH=32, RATIO=2, addr 31 gives lanes {word31, word0}.
- Write arbitration:
  - A port is granted when its WriteEnable is 1 and it has at least one BE bit set.
  - If several enabled ports target the same address, the lowest index wins; higher ports get WriteGrant=0 and their write is dropped.
  - Ports targeting distinct addresses all complete in the same cycle.
- Write pipeline:
  - At posedge E, granted data, BE and the address one-hot are sampled into staging registers.
  - A global clock gate enabled by any grant drives per-word × per-byte clock gates.
  - Latches are transparent during the high phase after E; the word is updated by mid-cycle after E.
- Read-after-write:
  - A read registered at a later edge than E returns the new data.
  - A read registered at the same edge E as the write returns the new data for that lane by cycle end (write-first). The bench samples at the next posedge only.
- Unselected bytes (BE=0) are retained.
- Async reset asserted mid-write: staging one-hot clears, the latch write aborts, and the word content is undefined. Reads of other words are unaffected.
- Clock-gate test enable tied 0.

Decomposition:
- Package scm_pkg:
  - function for wrap-add of the lane address.
  - localparams for DEPTH and byte count derivation.
- One sub-module, scm_write_arbiter: per-address fixed-priority resolution producing WriteGrant and the per-word × per-byte one-hot.
- Clock gating reuses cluster_clock_gating.

Test Plan:
1. Reset then write words 0..31 with value 0x1000+i, full BE, port 0 → reading addr 4 gives lanes {0x1004, 0x1005}, ReadValid=1 one cycle after the request.
2. Wrap-around → read addr 31 returns {0x101F, 0x1000}. With RATIO=4 configured, addr 30 returns {0x101E, 0x101F, 0x1000, 0x1001}.
3. Byte enables: word 7=0xFFFF_FFFF_FFFF_FFFF, then write 0 with BE=0x0F → read gives 0xFFFF_FFFF_0000_0000.
4. N_WRITE=2 collision: both ports write addr 9 (port0 0xAA, port1 0xBB) → WriteGrant=2'b01, word 9 =0xAA. Distinct addrs 9/10 → both granted and written.
5. Same-edge write 0x55 to addr 12 while reading addr 12 → ReadData lane0=0x55 at next posedge. ReadEnable dropped next cycle → ReadValid=0, ReadData held.
6. rst_n pulsed low mid-sequence → ReadValid=0 and no WriteGrant-driven update occurs. Words not being written at reset time keep their values when read after reset.
